// File: rtl/config_chain_loader.sv
// config_chain_loader: initiator end of the serial configuration chain.
// Takes parallel words, shifts them MSB-first onto the chain head for exactly
// CHAIN_LENGTH bits, and gathers the bits ejected at the chain tail into
// readback words in the same format as the input words.
//
// Handshake: a word transfers on a rising edge where word_valid and word_ready
// are both high; word_ready depends only on loader state, never on
// word_valid, and word_valid outside WAIT_WORD is ignored.
module config_chain_loader #(
    parameter int CHAIN_LENGTH = 64,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                  config_clock,
    input  logic                  config_nreset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data,
    output logic                  chain_enable,
    input  logic                  chain_return,
    output logic [WORD_WIDTH-1:0] readback_data,
    output logic                  readback_valid,
    output logic [1:0]            state_dbg
);

    localparam int CBW = $clog2(CHAIN_LENGTH + 1);
    localparam int WBW = $clog2(WORD_WIDTH);
    localparam logic [CBW-1:0] CB_LAST = CBW'(CHAIN_LENGTH - 1);
    localparam logic [WBW-1:0] WB_LAST = WBW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CBW-1:0]        bit_cnt;
    logic [WBW-1:0]        word_bit;
    logic [WORD_WIDTH-1:0] sreg;
    logic [WORD_WIDTH-1:0] rb_acc;
    logic [WORD_WIDTH-1:0] rb_next;
    logic                  accept;
    logic                  chain_last;
    logic                  word_last;

    // All outputs are decoded from registers only.
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign word_ready   = (state == WAIT_WORD);
    assign chain_enable = (state == SHIFT);
    assign chain_data   = (state == SHIFT) & sreg[WORD_WIDTH-1];
    assign state_dbg    = state;

    // Returned bit lands at its position in the word, first arrival at the MSB,
    // so a partial last word is top-aligned with zeros below.
    assign rb_next = rb_acc
                   | ({{(WORD_WIDTH-1){1'b0}}, chain_return} << (WB_LAST - word_bit));

    // State register.
    always_ff @(posedge config_clock) begin
        if (!config_nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the word/chain boundary flags used by the datapath.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        chain_last = 1'b0;
        word_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = WAIT_WORD;
            end
            WAIT_WORD: begin
                if (word_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                chain_last = (bit_cnt == CB_LAST);
                word_last  = (word_bit == WB_LAST);
                if (chain_last) begin
                    state_next = DONE;
                end else if (word_last) begin
                    state_next = WAIT_WORD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register, counters and readback capture.
    always_ff @(posedge config_clock) begin
        if (!config_nreset) begin
            bit_cnt        <= '0;
            word_bit       <= '0;
            sreg           <= '0;
            rb_acc         <= '0;
            readback_data  <= '0;
            readback_valid <= 1'b0;
        end else begin
            readback_valid <= 1'b0;
            if ((state == IDLE) && start) begin
                bit_cnt  <= '0;
                word_bit <= '0;
            end
            if (accept) begin
                sreg   <= word_data;
                rb_acc <= '0;
            end
            if (state == SHIFT) begin
                sreg     <= {sreg[WORD_WIDTH-2:0], 1'b0};
                rb_acc   <= rb_next;
                bit_cnt  <= bit_cnt + 1'b1;
                word_bit <= word_last ? '0 : word_bit + 1'b1;
                // Partial last word: remaining sreg bits are simply dropped.
                if (chain_last || word_last) begin
                    readback_data  <= rb_next;
                    readback_valid <= 1'b1;
                end
            end
        end
    end

endmodule
